// File: rtl/mmu_s_sequencer.sv
// Job sequencer for the weight-stationary systolic array: loads one weight tile,
// streams activation vectors, then waits for the last result to leave the array.
module mmu_s_sequencer #(
  parameter int size      = 4,
  parameter int bit_width = 8,
  parameter int arr_width = size * bit_width,
  parameter int AW        = 8,
  parameter int CW        = 8,
  parameter int W_LAT     = 5,
  parameter int DRAIN_LAT = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CW-1:0]        num_vec,
  input  logic [AW-1:0]        wt_base,
  input  logic [AW-1:0]        act_base,
  output logic                 wt_rd_en,
  output logic [AW-1:0]        wt_rd_addr,
  input  logic [arr_width-1:0] wt_rd_data,
  output logic                 act_rd_en,
  output logic [AW-1:0]        act_rd_addr,
  input  logic [arr_width-1:0] act_rd_data,
  output logic                 mmu_control,
  output logic [arr_width-1:0] mmu_wt_arr,
  output logic [arr_width-1:0] mmu_data_arr,
  output logic                 res_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_W, STREAM, DRAIN, DONE} state_t;

  // The per-state cycle counter is CW bits, so size and W_LAT must fit in CW.
  localparam logic [CW-1:0] SIZE_LAST = CW'(size - 1);
  localparam logic [CW-1:0] WLAT_LAST = CW'(W_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d;
  logic [CW-1:0] num_vec_q, num_vec_d;
  logic [AW-1:0] wt_base_q, wt_base_d;
  logic [AW-1:0] act_base_q, act_base_d;

  logic          wt_rd_en_q, wt_rd_en_d;
  logic [AW-1:0] wt_rd_addr_q, wt_rd_addr_d;
  logic          act_rd_en_q, act_rd_en_d;
  logic [AW-1:0] act_rd_addr_q, act_rd_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mmu_control_q;
  logic [DRAIN_LAT:0] act_dly_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_cnt_d  = res_cnt_q;
    num_vec_d  = num_vec_q;
    wt_base_d  = wt_base_q;
    act_base_d = act_base_q;
    if (res_valid) res_cnt_d = res_cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_W;
          cnt_d      = '0;
          res_cnt_d  = '0;
          num_vec_d  = num_vec;
          wt_base_d  = wt_base;
          act_base_d = act_base;
        end
      end
      LOAD_W: begin
        if (cnt_q == SIZE_LAST) begin
          state_d = WAIT_W;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_W: begin
        if (cnt_q == WLAT_LAST) begin
          state_d = (num_vec_q != '0) ? STREAM : DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STREAM: begin
        if (cnt_q == num_vec_q - CW'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (res_valid && (res_cnt_q == num_vec_q - CW'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    wt_rd_en_d    = (state_d == LOAD_W);
    wt_rd_addr_d  = wt_rd_en_d ? wt_base_d + AW'(cnt_d) : '0;
    act_rd_en_d   = (state_d == STREAM);
    act_rd_addr_d = act_rd_en_d ? act_base_d + AW'(cnt_d) : '0;
    busy_d        = (state_d == LOAD_W) || (state_d == WAIT_W) ||
                    (state_d == STREAM) || (state_d == DRAIN);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      res_cnt_q     <= '0;
      num_vec_q     <= '0;
      wt_base_q     <= '0;
      act_base_q    <= '0;
      wt_rd_en_q    <= 1'b0;
      wt_rd_addr_q  <= '0;
      act_rd_en_q   <= 1'b0;
      act_rd_addr_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mmu_control_q <= 1'b0;
      act_dly_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      res_cnt_q     <= res_cnt_d;
      num_vec_q     <= num_vec_d;
      wt_base_q     <= wt_base_d;
      act_base_q    <= act_base_d;
      wt_rd_en_q    <= wt_rd_en_d;
      wt_rd_addr_q  <= wt_rd_addr_d;
      act_rd_en_q   <= act_rd_en_d;
      act_rd_addr_q <= act_rd_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mmu_control_q <= wt_rd_en_q;
      // Tap 0 marks activation data on the array input; the last tap is the result strobe.
      act_dly_q     <= {act_dly_q[DRAIN_LAT-1:0], act_rd_en_q};
    end
  end

  assign wt_rd_en     = wt_rd_en_q;
  assign wt_rd_addr   = wt_rd_addr_q;
  assign act_rd_en    = act_rd_en_q;
  assign act_rd_addr  = act_rd_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mmu_control  = mmu_control_q;
  assign res_valid    = act_dly_q[DRAIN_LAT];
  assign mmu_wt_arr   = mmu_control_q ? wt_rd_data : '0;
  assign mmu_data_arr = act_dly_q[0] ? act_rd_data : '0;

endmodule

// File: tb/tb_mmu_s_sequencer.sv
// Self-checking bench for mmu_s_sequencer: directed and random jobs compared
// cycle by cycle against a timeline model derived from the job cycle map.
module tb_mmu_s_sequencer;
  localparam int SIZE = 4, BW = 8, ARR = 32, AW = 8, CW = 8, W_LAT = 5, DRAIN_LAT = 10;
  localparam int T = 1 + SIZE + W_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic [AW-1:0] wt_base = '0, act_base = '0;
  logic wt_rd_en, act_rd_en, mmu_control, res_valid, busy, done;
  logic [AW-1:0] wt_rd_addr, act_rd_addr;
  logic [ARR-1:0] wt_rd_data = '0, act_rd_data = '0;
  logic [ARR-1:0] mmu_wt_arr, mmu_data_arr;

  logic [ARR-1:0] wmem [256];
  logic [ARR-1:0] amem [256];

  int cyc = 0, t0 = 0, m_n = 0;
  bit job_on = 0, fresh = 1;
  logic [AW-1:0] m_wb = '0, m_ab = '0;
  int n_checks = 0, n_fail = 0;

  mmu_s_sequencer #(.size(SIZE), .bit_width(BW), .arr_width(ARR), .AW(AW), .CW(CW),
                    .W_LAT(W_LAT), .DRAIN_LAT(DRAIN_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .wt_base(wt_base), .act_base(act_base),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .mmu_control(mmu_control), .mmu_wt_arr(mmu_wt_arr), .mmu_data_arr(mmu_data_arr),
    .res_valid(res_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Buffer SRAMs with one-cycle registered read.
  always @(posedge clk) begin
    if (wt_rd_en) wt_rd_data <= wmem[wt_rd_addr];
    if (act_rd_en) act_rd_data <= amem[act_rd_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int done_rel();
    return (m_n == 0) ? T : T + DRAIN_LAT + m_n + 1;
  endfunction

  function automatic bit model_idle();
    return !job_on || ((cyc - t0) > done_rel());
  endfunction

  task automatic check_cycle();
    int rel, d;
    logic e_wen, e_ctl, e_aen, e_rv, e_busy, e_done;
    logic [AW-1:0] e_waddr, e_aaddr, idx;
    logic [ARR-1:0] e_warr, e_darr;
    e_wen = 0; e_ctl = 0; e_aen = 0; e_rv = 0; e_busy = 0; e_done = 0;
    e_waddr = '0; e_aaddr = '0; e_warr = '0; e_darr = '0;
    if (job_on) begin
      rel = cyc - t0;
      d = done_rel();
      e_wen = (rel >= 1 && rel <= SIZE);
      if (e_wen) e_waddr = m_wb + AW'(rel - 1);
      e_ctl = (rel >= 2 && rel <= SIZE + 1);
      if (e_ctl) begin
        idx = m_wb + AW'(rel - 2);
        e_warr = wmem[idx];
      end
      e_aen = (rel >= T && rel <= T + m_n - 1);
      if (e_aen) e_aaddr = m_ab + AW'(rel - T);
      if (rel >= T + 1 && rel <= T + m_n) begin
        idx = m_ab + AW'(rel - T - 1);
        e_darr = amem[idx];
      end
      e_rv   = (rel >= T + 1 + DRAIN_LAT && rel <= T + DRAIN_LAT + m_n);
      e_busy = (rel >= 1 && rel < d);
      e_done = (rel == d);
    end
    check_eq("wt_rd_en", 32'(wt_rd_en), 32'(e_wen));
    if (e_wen || fresh) check_eq("wt_rd_addr", 32'(wt_rd_addr), 32'(e_waddr));
    check_eq("act_rd_en", 32'(act_rd_en), 32'(e_aen));
    if (e_aen || fresh) check_eq("act_rd_addr", 32'(act_rd_addr), 32'(e_aaddr));
    check_eq("mmu_control", 32'(mmu_control), 32'(e_ctl));
    check_eq("mmu_wt_arr", mmu_wt_arr, e_warr);
    check_eq("mmu_data_arr", mmu_data_arr, e_darr);
    check_eq("res_valid", 32'(res_valid), 32'(e_rv));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("done", 32'(done), 32'(e_done));
  endtask

  // One clock cycle: drive inputs, update the model, check outputs mid-cycle.
  task automatic step(input logic s, input logic rn, input logic [CW-1:0] nv,
                      input logic [AW-1:0] wb, input logic [AW-1:0] ab);
    start = s; rst_n = rn; num_vec = nv; wt_base = wb; act_base = ab;
    if (rn && s && model_idle()) begin
      job_on = 1; t0 = cyc; m_n = int'(nv); m_wb = wb; m_ab = ab; fresh = 0;
      $display("job @%0d: num_vec=%0d wt_base=%h act_base=%h", cyc, nv, wb, ab);
    end
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (!rn) begin
      job_on = 0; fresh = 1;
      $display("reset @%0d", cyc);
    end
    cyc++;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      wmem[i] = {4{8'(i)}};
      amem[i] = 32'h04030201 + 32'(i);
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state held, then nominal job with ignored starts at 5 and 22, restart at 25.
    step(1'b0, 1'b0, '0, '0, '0);
    for (int c = 0; c < 60; c++)
      step((c == 0) || (c == 5) || (c == 22) || (c == 25), 1'b1, 8'd3, 8'h10, 8'h40);
    // Zero-length job.
    for (int c = 0; c < 15; c++) step(c == 0, 1'b1, 8'd0, 8'h20, 8'h50);
    // Activation address wrap.
    for (int c = 0; c < 30; c++) step(c == 0, 1'b1, 8'd4, 8'hFD, 8'hFE);
    // Reset mid-job.
    for (int c = 0; c < 30; c++) step(c == 0, c != 12, 8'd3, 8'h10, 8'h40);

    for (int i = 0; i < 256; i++) begin
      wmem[i] = $urandom;
      amem[i] = $urandom;
    end

    for (int j = 0; j < 40; j++) begin
      logic [CW-1:0] nv;
      logic [AW-1:0] wb, ab;
      int rst_at, len;
      nv = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 2)) : CW'($urandom_range(1, 24));
      wb = AW'($urandom);
      ab = AW'($urandom);
      len = T + DRAIN_LAT + int'(nv) + 2 + int'($urandom_range(0, 4));
      rst_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, T + DRAIN_LAT + 4)) : -1;
      for (int c = 0; c < len; c++) begin
        if (c == 0) step(1'b1, 1'b1, nv, wb, ab);
        else step($urandom_range(0, 4) == 0, c != rst_at,
                  CW'($urandom_range(0, 30)), AW'($urandom), AW'($urandom));
      end
    end
    idle_run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
